fifo_read_arbiter: RTL and testbench

- Shares the single prefetch-FIFO read port between the instruction-stream consumers:
  - index 0: opcode fetch
  - index 1: ModR/M decode
  - index 2: immediate fetch
- Grants ownership to one requester at a time and holds it until that requester releases.
- Gates `fifo_rd_en` and the per-requester empty view accordingly.
- Counts bytes popped for the current instruction, for IP advance.

---
 rtl/fifo_arb_pkg.sv | 46 ++++
 rtl/arb_priority_pick.sv | 18 +
 rtl/fifo_read_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_read_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, requester indices and the rotating winner search for the prefetch-FIFO read arbiter.
// Latency: none, purely declarative plus one combinational helper function.
// Backpressure: not applicable.
package fifo_arb_pkg;

    // Arbiter ownership state: IDLE means no grant, OWNED means exactly one grant bit set.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Requester indices on the shared read port.
    localparam int REQ_OPCODE = 0;
    localparam int REQ_MODRM  = 1;
    localparam int REQ_IMMED  = 2;

    // The picker works on a fixed 8-wide vector so that one function serves every NUM_REQ.
    // Unused upper bits are zero, so wrapping modulo 8 visits the live indices in the same
    // order as wrapping modulo NUM_REQ, provided start < NUM_REQ.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // Returns the one-hot first set bit of (req & mask), searching upward from start and wrapping.
    function automatic logic [MAX_REQ-1:0] pick_winner(
        input logic [MAX_REQ-1:0] req,
        input logic [MAX_REQ-1:0] mask,
        input logic [IDX_W-1:0]   start
    );
        logic [MAX_REQ-1:0] eligible;
        logic [MAX_REQ-1:0] onehot;
        logic               found;
        logic [IDX_W-1:0]   idx;
        eligible = req & mask;
        onehot   = '0;
        found    = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = start + IDX_W'(i);
            if (!found && eligible[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Masked priority picker with a rotating start index; one-hot or zero result.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is used.
module arb_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] winner
);

    // Widen to the package search width and truncate back; upper bits can never win.
    assign winner = NUM_REQ'(pick_winner(MAX_REQ'(req), MAX_REQ'(mask), start));

endmodule

// File: rtl/fifo_read_arbiter.sv
// Grants the shared prefetch-FIFO read port to one consumer at a time and counts bytes popped per instruction.
// Latency: grant registered 1 cycle after req; fifo_rd_en and the per-requester empty view are combinational.
// Backpressure: non-owners see empty and never pop; owner keeps grant while FIFO is empty. FIFO_ARB_ROUND_ROBIN_EN selects round-robin.
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 instr_start,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rd_en,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   req_fifo_empty,
    output logic                 busy,
    output logic                 fifo_rd_en,
    input  logic                 fifo_empty,
    output logic [CNT_WIDTH-1:0] bytes_popped,
    output logic                 conflict
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDX_W-1:0]   pick_start;
    logic               owner_holds;

    // The releasing owner is masked out so handover never re-grants the same index.
    assign pick_mask   = ~grant;
    assign owner_holds = |(grant & req);

`ifdef FIFO_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_owner;
    logic             new_grant;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // A handover always changes the grant vector, so any change to a non-zero grant is a new owner.
    assign new_grant  = (|grant_nxt) && (grant_nxt != grant);
    assign pick_start = (last_owner == IDX_W'(NUM_REQ - 1)) ? '0 : last_owner + 1'b1;

    // Remember the most recent owner; flush deliberately leaves it alone to keep fairness.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= '0;
        end else if (new_grant) begin
            last_owner <= onehot_to_idx(grant_nxt);
        end
    end
`else
    assign pick_start = '0;
`endif

    arb_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .start  (pick_start),
        .winner (winner)
    );

    // Next ownership: flush drops everything, otherwise grant from IDLE or hand over on release.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        if (flush) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state_nxt = ST_OWNED;
                        grant_nxt = winner;
                    end
                end
                ST_OWNED: begin
                    if (!owner_holds) begin
                        grant_nxt = winner;
                        state_nxt = (|winner) ? ST_OWNED : ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            endcase
        end
    end

    // Ownership state and grant register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Port gating: only the owner's strobe reaches the FIFO, never during a flush cycle.
    assign fifo_rd_en     = (|(grant & req_rd_en)) & ~fifo_empty & ~flush;
    assign req_fifo_empty = {NUM_REQ{fifo_empty}} | ~grant;
    assign busy           = |grant;

    // Per-instruction byte count; an instruction boundary restarts it, counting a same-cycle pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            bytes_popped <= '0;
        end else if (instr_start) begin
            bytes_popped <= fifo_rd_en ? CNT_WIDTH'(1) : '0;
        end else if (fifo_rd_en && (bytes_popped != CNT_MAX)) begin
            bytes_popped <= bytes_popped + 1'b1;
        end
    end

    // Sticky record of any strobe from a requester that does not own the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict <= 1'b0;
        end else if (|(req_rd_en & ~grant)) begin
            conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed self-checking bench for fifo_read_arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after input changes or edges.
// Backpressure: exercises empty FIFO, non-owner strobes, flush and reset mid-ownership.
module tb_fifo_read_arbiter;
    import fifo_arb_pkg::*;

    localparam logic [2:0] B_OP = 3'(1 << REQ_OPCODE);
    localparam logic [2:0] B_MR = 3'(1 << REQ_MODRM);
    localparam logic [2:0] B_IM = 3'(1 << REQ_IMMED);

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       instr_start;
    logic [2:0] req;
    logic [2:0] req_rd_en;
    logic [2:0] grant;
    logic [2:0] req_fifo_empty;
    logic       busy;
    logic       fifo_rd_en;
    logic       fifo_empty;
    logic [3:0] bytes_popped;
    logic       conflict;

    int checks = 0;
    int errors = 0;

    fifo_read_arbiter #(
        .NUM_REQ   (3),
        .CNT_WIDTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .instr_start    (instr_start),
        .req            (req),
        .req_rd_en      (req_rd_en),
        .grant          (grant),
        .req_fifo_empty (req_fifo_empty),
        .busy           (busy),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_empty     (fifo_empty),
        .bytes_popped   (bytes_popped),
        .conflict       (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        instr_start = 1'b0;
        req         = '0;
        req_rd_en   = '0;
        fifo_empty  = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_grant", grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_empty_view", req_fifo_empty, 3'b111);
        check("rst_bytes", bytes_popped, 4'd0);
        check("rst_conflict", conflict, 1'b0);

        // Single requester: 1-cycle grant latency, two pops
        reset = 1'b0;
        req   = B_MR;
        #1;
        check("t1_no_grant_yet", grant, 3'b000);
        cyc();
        check("t1_grant", grant, 3'b010);
        check("t1_busy", busy, 1'b1);
        req_rd_en = B_MR;
        #1;
        check("t1_rd_en", fifo_rd_en, 1'b1);
        check("t1_empty_view", req_fifo_empty, 3'b101);
        cyc();
        cyc();
        req_rd_en = '0;
        #1;
        check("t1_rd_en_off", fifo_rd_en, 1'b0);
        check("t1_bytes", bytes_popped, 4'd2);
        req = '0;
        cyc();
        check("t1_release", grant, 3'b000);
        check("t1_idle_busy", busy, 1'b0);

        // Simultaneous requests
        req = 3'b111;
        cyc();
`ifdef FIFO_ARB_ROUND_ROBIN_EN
        check("t2_rr_first", grant, 3'b100);
        req = 3'b011;
        cyc();
        check("t2_rr_handover", grant, 3'b001);
`else
        check("t2_fixed_first", grant, 3'b001);
        req = 3'b110;
        cyc();
        check("t2_fixed_handover", grant, 3'b010);
        req = 3'b100;
        cyc();
        check("t2_fixed_handover2", grant, 3'b100);
`endif
        req = '0;
        cyc();
        check("t2_idle", grant, 3'b000);

        // Non-owner strobe
        req = B_OP;
        cyc();
        check("t3_grant", grant, 3'b001);
        req_rd_en = B_IM;
        #1;
        check("t3_no_pop", fifo_rd_en, 1'b0);
        check("t3_empty_view", req_fifo_empty, 3'b110);
        check("t3_conflict_pre", conflict, 1'b0);
        cyc();
        req_rd_en = '0;
        #1;
        check("t3_conflict", conflict, 1'b1);
        check("t3_bytes_same", bytes_popped, 4'd2);
        cyc();
        check("t3_conflict_sticky", conflict, 1'b1);

        // Counter limits
        instr_start = 1'b1;
        cyc();
        check("t4_start_clear", bytes_popped, 4'd0);
        instr_start = 1'b0;
        req_rd_en   = B_OP;
        repeat (14) cyc();
        check("t4_bytes14", bytes_popped, 4'd14);
        repeat (3) cyc();
        check("t4_saturate", bytes_popped, 4'd15);
        instr_start = 1'b1;
        cyc();
        check("t4_start_pop", bytes_popped, 4'd1);
        req_rd_en = '0;
        cyc();
        check("t4_start_only", bytes_popped, 4'd0);
        instr_start = 1'b0;

        // Flush mid-transfer
        req = B_MR;
        cyc();
        check("t5_handover", grant, 3'b010);
        req_rd_en = B_MR;
        cyc();
        check("t5_bytes", bytes_popped, 4'd1);
        flush = 1'b1;
        #1;
        check("t5_flush_no_pop", fifo_rd_en, 1'b0);
        cyc();
        flush     = 1'b0;
        req_rd_en = '0;
        #1;
        check("t5_grant_dropped", grant, 3'b000);
        check("t5_busy", busy, 1'b0);
        check("t5_bytes_clr", bytes_popped, 4'd0);
        check("t5_conflict_kept", conflict, 1'b1);
        cyc();
        check("t5_regrant", grant, 3'b010);

        // Empty FIFO: owner holds, no pop, no count change
        req = B_IM;
        cyc();
        check("t6_grant", grant, 3'b100);
        req_rd_en = B_IM;
        cyc();
        check("t6_bytes", bytes_popped, 4'd1);
        fifo_empty = 1'b1;
        #1;
        check("t6_no_pop", fifo_rd_en, 1'b0);
        check("t6_empty_view", req_fifo_empty, 3'b111);
        cyc();
        cyc();
        check("t6_grant_held", grant, 3'b100);
        check("t6_bytes_same", bytes_popped, 4'd1);

        // Reset while owned
        req_rd_en  = '0;
        fifo_empty = 1'b0;
        reset      = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("t7_grant", grant, 3'b000);
        check("t7_busy", busy, 1'b0);
        check("t7_conflict", conflict, 1'b0);
        check("t7_bytes", bytes_popped, 4'd0);
        cyc();
        check("t7_regrant", grant, 3'b100);
        req = '0;
        cyc();
        check("t7_idle", grant, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
